equal_run_generator: RTL and testbench

Stimulus transmitter for the equal-input run detector in the Lab 5 sequential-logic set. On a start request it emits a programmed number of bursts on a pair of serial lines `data_out_A`/`data_out_B`. Each burst is `match_len` cycles with A==B followed by `gap_len` cycles with A!=B, and the A values are pseudo-random. It also drives `expect_out`, the cycle-accurate output a threshold-4 Moore equality detector must produce when fed these lines, for self-checking benches and board demos.

---
 rtl/equal_run_generator.sv | 161 ++++++++++++++++
 tb/tb_equal_run_generator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/equal_run_generator.sv
// rtl/equal_run_generator.sv - burst stimulus generator for an equal-input run detector
// Emits equal/unequal bursts on A/B plus the expected threshold-4 Moore detector output.
module equal_run_generator #(
  parameter int          LEN_W     = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] match_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [3:0]       repeat_cnt,
  output logic             data_out_A,
  output logic             data_out_B,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             expect_out,
  output logic [3:0]       burst_cnt
);

  typedef enum logic [1:0] {IDLE, MATCH, GAP, DONE} state_t;

  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] mlen_q, mlen_d;
  logic [LEN_W-1:0] glen_q, glen_d;
  logic [3:0]       rep_q, rep_d;
  logic [3:0]       burst_q, burst_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [2:0]       r_q, r_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             expect_q, expect_d;
  logic [4:0]       burst_inc;
  logic             lfsr_fb;

  assign burst_inc = {1'b0, burst_q} + 5'd1;
  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // cnt_q holds the number of cycles left in the current phase after this one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mlen_d  = mlen_q;
    glen_d  = glen_q;
    rep_d   = rep_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mlen_d  = match_len;
          glen_d  = (gap_len == '0) ? LEN_W'(1) : gap_len;
          rep_d   = (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
          burst_d = 4'd0;
          if (match_len != '0) begin
            state_d = MATCH;
            cnt_d   = match_len - LEN_W'(1);
          end else begin
            state_d = GAP;
            cnt_d   = glen_d - LEN_W'(1);
          end
        end
      end
      MATCH: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = glen_q - LEN_W'(1);
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          burst_d = burst_q + 4'd1;
          if (burst_inc < {1'b0, rep_q}) begin
            if (mlen_q != '0) begin
              state_d = MATCH;
              cnt_d   = mlen_q - LEN_W'(1);
            end else begin
              state_d = GAP;
              cnt_d   = glen_q - LEN_W'(1);
            end
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the state the next cycle will be in.
    valid_d = (state_d == MATCH) || (state_d == GAP);
    done_d  = (state_d == DONE);
    a_d     = valid_d & lfsr_q[0];
    if (state_d == MATCH) begin
      b_d = a_d;
    end else if (state_d == GAP) begin
      b_d = ~a_d;
    end else begin
      b_d = 1'b1;
    end
    lfsr_d = valid_d ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;

    // Run model follows the lines currently driven, so expect_out lags by one cycle.
    if (a_q == b_q) begin
      r_d = (r_q == 3'd7) ? 3'd7 : r_q + 3'd1;
    end else begin
      r_d = 3'd0;
    end
    expect_d = r_d[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mlen_q   <= '0;
      glen_q   <= '0;
      rep_q    <= 4'd0;
      burst_q  <= 4'd0;
      lfsr_q   <= SEED_EFF;
      r_q      <= 3'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b1;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      expect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mlen_q   <= mlen_d;
      glen_q   <= glen_d;
      rep_q    <= rep_d;
      burst_q  <= burst_d;
      lfsr_q   <= lfsr_d;
      r_q      <= r_d;
      a_q      <= a_d;
      b_q      <= b_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      expect_q <= expect_d;
    end
  end

  assign data_out_A = a_q;
  assign data_out_B = b_q;
  assign valid      = valid_q;
  assign busy       = valid_q;
  assign done       = done_q;
  assign expect_out = expect_q;
  assign burst_cnt  = burst_q;

endmodule

// File: tb/tb_equal_run_generator.sv
// tb/tb_equal_run_generator.sv - directed self-checking bench for equal_run_generator
module tb_equal_run_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] match_len;
  logic [3:0] gap_len;
  logic [3:0] repeat_cnt;
  logic       data_out_A;
  logic       data_out_B;
  logic       valid;
  logic       busy;
  logic       done;
  logic       expect_out;
  logic [3:0] burst_cnt;

  int checks = 0;
  int errors = 0;

  logic a_log [0:255];
  logic b_log [0:255];
  logic e_log [0:255];
  int   done_idx;
  int   nvalid;
  int   nexp;
  int   neq;
  int   busy_err;
  logic done_busy;

  equal_run_generator #(.LEN_W(4), .LFSR_SEED(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .match_len  (match_len),
    .gap_len    (gap_len),
    .repeat_cnt (repeat_cnt),
    .data_out_A (data_out_A),
    .data_out_B (data_out_B),
    .valid      (valid),
    .busy       (busy),
    .done       (done),
    .expect_out (expect_out),
    .burst_cnt  (burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench sampling the first valid cycle of the new request.
  task automatic issue_start(input logic [3:0] m, input logic [3:0] g, input logic [3:0] r);
    step();
    match_len  = m;
    gap_len    = g;
    repeat_cnt = r;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic collect(input int pulse_at);
    done_idx = -1;
    nvalid = 0;
    nexp = 0;
    neq = 0;
    busy_err = 0;
    done_busy = 1'bx;
    for (int i = 0; i < 200; i++) begin
      a_log[i] = data_out_A;
      b_log[i] = data_out_B;
      e_log[i] = expect_out;
      if (valid) begin
        nvalid++;
        if (data_out_A == data_out_B) neq++;
      end
      if (busy !== valid) busy_err++;
      if (expect_out) nexp++;
      if (done) begin
        done_idx  = i;
        done_busy = busy;
        break;
      end
      start = (i == pulse_at);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    match_len = 4'd0;
    gap_len = 4'd0;
    repeat_cnt = 4'd0;
    step();
    step();
    reset = 1'b0;
    checks++;
    if ({data_out_A, data_out_B, valid, busy, done, expect_out} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 010000",
               {data_out_A, data_out_B, valid, busy, done, expect_out});
    end
    checks++;
    if (burst_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_burst_cnt got %0d expected 0", burst_cnt);
    end
  endtask

  task automatic test_single_burst();
    logic [5:0] got_a;
    logic [5:0] got_b;
    logic [6:0] got_e;
    issue_start(4'd4, 4'd2, 4'd1);
    collect(-1);
    for (int i = 0; i < 6; i++) begin
      got_a[i] = a_log[i];
      got_b[i] = b_log[i];
    end
    for (int i = 0; i < 7; i++) got_e[i] = e_log[i];
    checks++;
    if (got_a !== 6'b100101) begin
      errors++;
      $display("FAIL single_a_seq got %b expected 100101", got_a);
    end
    checks++;
    if (got_b !== 6'b010101) begin
      errors++;
      $display("FAIL single_b_seq got %b expected 010101", got_b);
    end
    checks++;
    if (got_e !== 7'b0010000) begin
      errors++;
      $display("FAIL single_expect got %b expected 0010000", got_e);
    end
    checks++;
    if (done_idx !== 6 || nvalid !== 6) begin
      errors++;
      $display("FAIL single_done_idx got %0d/%0d valid expected 6/6", done_idx, nvalid);
    end
    checks++;
    if (done_busy !== 1'b0 || busy_err !== 0) begin
      errors++;
      $display("FAIL single_busy got done_busy=%b busy_err=%0d expected 0/0", done_busy, busy_err);
    end
    checks++;
    if (burst_cnt !== 4'd1) begin
      errors++;
      $display("FAIL single_burst_cnt got %0d expected 1", burst_cnt);
    end
  endtask

  task automatic test_short_match();
    issue_start(4'd3, 4'd1, 4'd2);
    collect(-1);
    checks++;
    if (nvalid !== 8 || done_idx !== 8) begin
      errors++;
      $display("FAIL short_valid got %0d valid done@%0d expected 8 done@8", nvalid, done_idx);
    end
    checks++;
    if (nexp !== 0) begin
      errors++;
      $display("FAIL short_expect got %0d high cycles expected 0", nexp);
    end
    checks++;
    if (burst_cnt !== 4'd2) begin
      errors++;
      $display("FAIL short_burst_cnt got %0d expected 2", burst_cnt);
    end
  endtask

  // Start held through the DONE cycle: ignored there, accepted on the following IDLE edge.
  task automatic test_back_to_back();
    match_len = 4'd3;
    gap_len = 4'd1;
    repeat_cnt = 4'd1;
    start = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_edge_ignored got valid=%b expected 0", valid);
    end
    step();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_edge_accepted got valid=%b expected 1", valid);
    end
    collect(-1);
    checks++;
    if (nvalid !== 4 || burst_cnt !== 4'd1) begin
      errors++;
      $display("FAIL b2b_run got %0d valid burst=%0d expected 4 burst=1", nvalid, burst_cnt);
    end
  endtask

  task automatic test_long_match();
    int rises;
    issue_start(4'd10, 4'd0, 4'd3);
    collect(-1);
    rises = 0;
    for (int i = 1; i <= done_idx; i++) if (e_log[i] && !e_log[i-1]) rises++;
    checks++;
    if (nvalid !== 33 || done_idx !== 33) begin
      errors++;
      $display("FAIL long_valid got %0d valid done@%0d expected 33 done@33", nvalid, done_idx);
    end
    checks++;
    if (nexp !== 21 || rises !== 3) begin
      errors++;
      $display("FAIL long_expect got %0d high in %0d runs expected 21 in 3", nexp, rises);
    end
    checks++;
    if (burst_cnt !== 4'd3) begin
      errors++;
      $display("FAIL long_burst_cnt got %0d expected 3", burst_cnt);
    end
  endtask

  task automatic test_zero_match();
    issue_start(4'd0, 4'd5, 4'd0);
    collect(-1);
    checks++;
    if (nvalid !== 5 || done_idx !== 5) begin
      errors++;
      $display("FAIL zero_valid got %0d valid done@%0d expected 5 done@5", nvalid, done_idx);
    end
    checks++;
    if (neq !== 0 || nexp !== 0) begin
      errors++;
      $display("FAIL zero_lines got eq=%0d exp=%0d expected 0/0", neq, nexp);
    end
    checks++;
    if (burst_cnt !== 4'd1) begin
      errors++;
      $display("FAIL zero_burst_cnt got %0d expected 1", burst_cnt);
    end
  endtask

  task automatic test_mid_start();
    issue_start(4'd4, 4'd2, 4'd2);
    collect(3);
    checks++;
    if (nvalid !== 12 || done_idx !== 12) begin
      errors++;
      $display("FAIL midstart_valid got %0d valid done@%0d expected 12 done@12", nvalid, done_idx);
    end
    checks++;
    if (burst_cnt !== 4'd2) begin
      errors++;
      $display("FAIL midstart_burst_cnt got %0d expected 2", burst_cnt);
    end
  endtask

  task automatic test_reset_mid_match();
    logic [5:0] first_a;
    logic [5:0] second_a;
    reset = 1'b1;
    step();
    reset = 1'b0;
    issue_start(4'd10, 4'd1, 4'd1);
    for (int i = 0; i < 6; i++) begin
      first_a[i] = data_out_A;
      if (i < 5) step();
    end
    checks++;
    if (expect_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_expect_before got %b expected 1", expect_out);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({data_out_A, data_out_B, valid, busy, done, expect_out, burst_cnt} !== 10'b0100000000) begin
      errors++;
      $display("FAIL rst_mid_outputs got %b expected 0100000000",
               {data_out_A, data_out_B, valid, busy, done, expect_out, burst_cnt});
    end
    issue_start(4'd10, 4'd1, 4'd1);
    for (int i = 0; i < 6; i++) begin
      second_a[i] = data_out_A;
      step();
    end
    checks++;
    if (first_a !== 6'b100101 || second_a !== 6'b100101) begin
      errors++;
      $display("FAIL rst_mid_replay got %b/%b expected 100101/100101", first_a, second_a);
    end
    collect(-1);
    checks++;
    if (done_idx !== 5 || nvalid !== 5) begin
      errors++;
      $display("FAIL rst_mid_finish got done@%0d with %0d valid expected 5/5", done_idx, nvalid);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_short_match();
    test_back_to_back();
    test_long_match();
    test_zero_match();
    test_mid_start();
    test_reset_mid_match();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
